ula_sequencer: RTL and testbench
================================

// Module: ula_sequencer
// PURPOSE
//  Command-driven controller for the shared 8-bit ALU (ops AND/OR/ADD/SUB with overflow flag).
//  - Accepts ops over a valid/ready command port.
//  - Drives the ALU operand/function inputs and captures its result and flag.
//  - Adds a multi-cycle unsigned multiply and an accumulate op, both built from repeated ALU ADDs.
//  - Returns results over a valid/ready response port.
//  - Sits between the instruction front-end and the ALU; it is the ALU's only master.
// PARAMETERS
//  N_BITS   8   datapath width; must match the ALU instance
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       sequencer can accept command (high only in IDLE)
//  cmd_op     in   3       0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 ACC (acc+=a), 6 CLR (acc=0), 7 reserved
//  cmd_a      in   N_BITS  operand A (two's complement for ADD/SUB/ACC)
//  cmd_b      in   N_BITS  operand B
//  alu_a      out  N_BITS  to ALU A
//  alu_b      out  N_BITS  to ALU B
//  alu_f      out  2       to ALU F (00 AND, 01 OR, 10 ADD, 11 SUB)
//  alu_y      in   N_BITS  ALU result (combinational from alu_a/alu_b/alu_f)
//  alu_ovf    in   1       ALU signed-overflow flag
//  rsp_valid  out  1       result available
//  rsp_ready  in   1       consumer takes result
//  rsp_data   out  N_BITS  result
//  rsp_ovf    out  1       overflow for this result
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except cmd_ready=1.
//  - acc=0; FSM in IDLE.
//  - Reset mid-operation aborts it; no response is produced.
//  States:
//  - IDLE: cmd_ready=1. On cmd_valid: latch op/a/b.
//    - ops 0-3, 5 -> EXEC.
//    - op 4 -> MUL with acc_m=0, step i=0.
//    - op 6 -> DONE with data=0, ovf=0; acc cleared.
//    - op 7 -> DONE with data=0, ovf=1.
//  - EXEC, 1 cycle: alu_a/alu_b/alu_f driven from registers.
//    - ACC uses alu_a=acc, alu_b=a, F=10.
//    - Capture alu_y/alu_ovf into rsp regs; ACC also writes acc=alu_y. -> DONE.
//  - MUL, exactly N_BITS cycles (i=0..N_BITS-1): alu_a=acc_m, alu_b=a<<i, F=10.
//    - If b[i], acc_m=alu_y.
//    - ovf is sticky unsigned: set if b[i] and (a>>(N_BITS-i))!=0, or b[i] and alu_y<acc_m (unsigned compare).
//    - After the last step -> DONE with data=acc_m (low N_BITS of the unsigned product).
//  - DONE: rsp_valid=1; rsp_data/rsp_ovf held stable until rsp_valid&&rsp_ready, then -> IDLE.
//  Outside EXEC/MUL: alu_a/alu_b/alu_f are held at 0 (F=00).
//  Latency, accept edge to rsp_valid high:
//  - ops 0-3, 5: 2 cycles.
//  - MUL: N_BITS+1 cycles.
//  - CLR/reserved: 1 cycle.
//  Throughput: cmd_ready=0 from accept until the response handshake completes; the next command is accepted no earlier than the cycle after.
//  Wrap-around: ADD/SUB/ACC results are modulo 2^N_BITS; rsp_ovf=alu_ovf as reported by the ALU.
//  Backpressure: rsp_ready low holds DONE indefinitely; no command is lost (cmd_ready stays 0).
// CONFIGURATION
//  ULA_SEQ_STATS_EN defined:
//  - Adds outputs stat_ops[15:0] (responses handshaken) and stat_ovf[15:0] (handshaken with rsp_ovf=1).
//  - Both counters saturate at 16'hFFFF, reset to 0, and increment on the rsp handshake cycle.
//  ULA_SEQ_STATS_EN undefined: counters and ports absent; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n low mid-MUL -> immediately rsp_valid=0, cmd_ready=1, alu_f=00; acc reads 0 via ACC a=0.
//  2. ADD a=8'd100, b=8'd27 -> rsp_data=127, rsp_ovf=0, 2 cycles. ADD a=8'd100, b=8'd28 -> rsp_data=8'h80, rsp_ovf=alu_ovf=1.
//  3. SUB a=-128, b=1 -> rsp_data=8'h7F, ovf=1. AND 8'hF0,8'h3C -> 8'h30. OR 8'hF0,8'h0F -> 8'hFF.
//  4. MUL 8'd13 x 8'd11 -> rsp_data=143, ovf=0, rsp_valid after 9 cycles. MUL 8'd16 x 8'd16 -> rsp_data=0, ovf=1.
//  5. ACC a=5 then ACC a=7 -> responses 5, 12. CLR -> 0; ACC a=3 -> 3. Op 7 -> data=0, ovf=1.
//  6. Hold rsp_ready=0 for 10 cycles after a MUL with cmd_valid high throughout -> rsp_data stable, cmd_ready=0, no second accept.
//     With STATS_EN, after tests 2-5: stat_ops/stat_ovf match the handshake count.

Source files
------------

// File: rtl/ula_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ula_sequencer
// Description : Command-driven controller and sole master of the shared
//               N_BITS-wide ALU (AND/OR/ADD/SUB with signed-overflow flag).
//               Accepts ops on a valid/ready command port, drives the ALU,
//               captures result/flag and returns them on a valid/ready
//               response port. Adds an accumulator op (ACC/CLR) and a
//               multi-cycle unsigned multiply built from repeated ALU ADDs.
//
//   Ports
//     clk, rst_n             clock (rising edge), async active-low reset
//     cmd_valid/cmd_ready    command handshake (ready only while idle)
//     cmd_op[2:0]            0 AND 1 OR 2 ADD 3 SUB 4 MUL 5 ACC 6 CLR 7 rsvd
//     cmd_a, cmd_b           operands
//     alu_a, alu_b, alu_f    ALU operand/function drive (0 when not in use)
//     alu_y, alu_ovf         ALU combinational result and overflow flag
//     rsp_valid/rsp_ready    response handshake
//     rsp_data, rsp_ovf      result and its overflow flag
//     stat_ops, stat_ovf     saturating response counters
//                            (only with ULA_SEQ_STATS_EN defined)
//
//   Build option : ULA_SEQ_STATS_EN adds the statistics counters and ports.
//
//   Revision     : 1.0  initial release
// ============================================================================
module ula_sequencer #(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [N_BITS-1:0] cmd_a,
    input  logic [N_BITS-1:0] cmd_b,
    output logic [N_BITS-1:0] alu_a,
    output logic [N_BITS-1:0] alu_b,
    output logic [1:0]        alu_f,
    input  logic [N_BITS-1:0] alu_y,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N_BITS-1:0] rsp_data,
    output logic              rsp_ovf
`ifdef ULA_SEQ_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_ovf
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [c_IW-1:0] c_I_LAST = c_IW'(N_BITS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_MUL  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [2:0] c_OP_MUL = 3'd4;
    localparam logic [2:0] c_OP_ACC = 3'd5;
    localparam logic [2:0] c_OP_CLR = 3'd6;
    localparam logic [2:0] c_OP_RSV = 3'd7;

    localparam logic [1:0] c_F_AND = 2'b00;
    localparam logic [1:0] c_F_ADD = 2'b10;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [2:0]          r_op;
    logic [N_BITS-1:0]   r_a;
    logic [N_BITS-1:0]   r_b;
    logic [N_BITS-1:0]   r_acc;
    logic [N_BITS-1:0]   r_acc_m;
    logic [c_IW-1:0]     r_i;
    logic                r_mul_ovf;
    logic [N_BITS-1:0]   r_rsp_data;
    logic                r_rsp_ovf;

    logic [2*N_BITS-1:0] w_a_ext;
    logic [N_BITS-1:0]   w_a_shift;
    logic                w_lost;
    logic                w_carry;
    logic                w_bit;
    logic                w_step_ovf;
    logic                w_mul_last;
    logic                w_accept;
    logic                w_rsp_hs;

    // Partial product a<<i computed double-width: bits shifted past the top
    // of the datapath are exactly (a >> (N_BITS-i)), i.e. product overflow.
    assign w_a_ext    = {{N_BITS{1'b0}}, r_a} << r_i;
    assign w_a_shift  = w_a_ext[N_BITS-1:0];
    assign w_lost     = |w_a_ext[2*N_BITS-1:N_BITS];
    // ADD wrapped around if the sum came out smaller than the addend.
    assign w_carry    = (alu_y < r_acc_m);
    assign w_bit      = r_b[r_i];
    assign w_step_ovf = w_bit & (w_lost | w_carry);
    assign w_mul_last = (r_i == c_I_LAST);

    assign w_accept   = (r_state == c_ST_IDLE) && cmd_valid;
    assign w_rsp_hs   = (r_state == c_ST_DONE) && rsp_ready;

    assign cmd_ready  = (r_state == c_ST_IDLE);
    assign rsp_valid  = (r_state == c_ST_DONE);
    assign rsp_data   = r_rsp_data;
    assign rsp_ovf    = r_rsp_ovf;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and ALU drive. ALU inputs are decoded from state so
    // they fall to zero the instant reset asserts.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        alu_a       = '0;
        alu_b       = '0;
        alu_f       = c_F_AND;
        case (r_state)
            c_ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        c_OP_MUL:           w_state_nxt = c_ST_MUL;
                        c_OP_CLR, c_OP_RSV: w_state_nxt = c_ST_DONE;
                        default:            w_state_nxt = c_ST_EXEC;
                    endcase
                end
            end
            c_ST_EXEC: begin
                if (r_op == c_OP_ACC) begin
                    alu_a = r_acc;
                    alu_b = r_a;
                    alu_f = c_F_ADD;
                end else begin
                    // ops 0-3 share their encoding with the ALU function
                    alu_a = r_a;
                    alu_b = r_b;
                    alu_f = r_op[1:0];
                end
                w_state_nxt = c_ST_DONE;
            end
            c_ST_MUL: begin
                alu_a = r_acc_m;
                alu_b = w_a_shift;
                alu_f = c_F_ADD;
                if (w_mul_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_acc_m    <= '0;
            r_i        <= '0;
            r_mul_ovf  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_ovf  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= cmd_op;
                        r_a       <= cmd_a;
                        r_b       <= cmd_b;
                        r_acc_m   <= '0;
                        r_i       <= '0;
                        r_mul_ovf <= 1'b0;
                        if (cmd_op == c_OP_CLR) begin
                            r_acc      <= '0;
                            r_rsp_data <= '0;
                            r_rsp_ovf  <= 1'b0;
                        end else if (cmd_op == c_OP_RSV) begin
                            r_rsp_data <= '0;
                            r_rsp_ovf  <= 1'b1;
                        end
                    end
                end
                c_ST_EXEC: begin
                    r_rsp_data <= alu_y;
                    r_rsp_ovf  <= alu_ovf;
                    if (r_op == c_OP_ACC) begin
                        r_acc <= alu_y;
                    end
                end
                c_ST_MUL: begin
                    if (w_bit) begin
                        r_acc_m <= alu_y;
                    end
                    r_mul_ovf <= r_mul_ovf | w_step_ovf;
                    r_i       <= r_i + 1'b1;
                    if (w_mul_last) begin
                        // final partial sum goes straight to the response
                        r_rsp_data <= w_bit ? alu_y : r_acc_m;
                        r_rsp_ovf  <= r_mul_ovf | w_step_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ULA_SEQ_STATS_EN
    // ------------------------------------------------------------------
    // Saturating response statistics, counted on the handshake cycle
    // ------------------------------------------------------------------
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops <= '0;
            r_stat_ovf <= '0;
        end else if (w_rsp_hs) begin
            if (r_stat_ops != 16'hFFFF) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if (r_rsp_ovf && (r_stat_ovf != 16'hFFFF)) begin
                r_stat_ovf <= r_stat_ovf + 16'd1;
            end
        end
    end

    assign stat_ops = r_stat_ops;
    assign stat_ovf = r_stat_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ula_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ula_sequencer
// Description : Self-checking bench for ula_sequencer. Contains a behavioural
//               8-bit ALU and an arithmetic reference model of every command;
//               directed cases followed by randomized commands with random
//               response backpressure, plus reset abort mid-multiply.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ula_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [N-1:0] cmd_a = '0;
    logic [N-1:0] cmd_b = '0;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_f;
    logic [N-1:0] alu_y;
    logic         alu_ovf;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_data;
    logic         rsp_ovf;
`ifdef ULA_SEQ_STATS_EN
    logic [15:0]  stat_ops;
    logic [15:0]  stat_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    logic [N-1:0] acc_q = '0;
    int           hs_ops = 0;
    int           hs_ovf = 0;

    always #5 clk = ~clk;

    ula_sequencer #(.N_BITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .alu_ovf   (alu_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf)
`ifdef ULA_SEQ_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_ovf  (stat_ovf)
`endif
    );

    // Behavioural ALU
    always_comb begin
        alu_y   = '0;
        alu_ovf = 1'b0;
        case (alu_f)
            2'b00: alu_y = alu_a & alu_b;
            2'b01: alu_y = alu_a | alu_b;
            2'b10: begin
                alu_y   = alu_a + alu_b;
                alu_ovf = (alu_a[N-1] == alu_b[N-1]) && (alu_y[N-1] != alu_a[N-1]);
            end
            default: begin
                alu_y   = alu_a - alu_b;
                alu_ovf = (alu_a[N-1] != alu_b[N-1]) && (alu_y[N-1] != alu_a[N-1]);
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: result, overflow and latency (cycles, accept edge counted
    // as cycle 1) for one command; updates the accumulator model.
    task automatic model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] d, output logic o, output int lat);
        int sa, sb, s, ia, ib, p;
        sa = $signed(a);
        sb = $signed(b);
        ia = a;
        ib = b;
        d = '0; o = 1'b0; lat = 2;
        case (op)
            3'd0: d = a & b;
            3'd1: d = a | b;
            3'd2: begin s = sa + sb; d = N'(s); o = (s > 127) || (s < -128); end
            3'd3: begin s = sa - sb; d = N'(s); o = (s > 127) || (s < -128); end
            3'd4: begin p = ia * ib; d = N'(p); o = (p > 255); lat = N + 1; end
            3'd5: begin
                s = $signed(acc_q);
                s = s + sa;
                d = N'(s);
                o = (s > 127) || (s < -128);
                acc_q = d;
            end
            3'd6: begin acc_q = '0; lat = 1; end
            default: begin o = 1'b1; lat = 1; end
        endcase
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input int hold, input bit keep_valid);
        logic [N-1:0] ed;
        logic         eo;
        int           el;
        int           edges;
        model(op, a, b, ed, eo, el);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        edges = 0;
        while (!cmd_ready && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep_valid) cmd_valid = 1'b0;
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 32'(edges), 32'(el));
        check("rsp_data", 32'(rsp_data), 32'(ed));
        check("rsp_ovf", 32'(rsp_ovf), 32'(eo));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(ed));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        hs_ops++;
        if (eo) hs_ovf++;
        check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_alu_f", 32'(alu_f), 32'd0);
        check("idle_alu_b", 32'(alu_b), 32'd0);
    endtask

    initial begin
        // ---- power-on reset ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("rst_alu_f", 32'(alu_f), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed cases ----
        run_cmd(3'd2, 8'd100, 8'd27, 0, 1'b0);
        run_cmd(3'd2, 8'd100, 8'd28, 0, 1'b0);
        run_cmd(3'd3, 8'h80, 8'd1, 0, 1'b0);
        run_cmd(3'd0, 8'hF0, 8'h3C, 0, 1'b0);
        run_cmd(3'd1, 8'hF0, 8'h0F, 0, 1'b0);
        run_cmd(3'd4, 8'd13, 8'd11, 0, 1'b0);
        run_cmd(3'd4, 8'd16, 8'd16, 0, 1'b0);
        run_cmd(3'd4, 8'd255, 8'd255, 0, 1'b0);
        run_cmd(3'd4, 8'd15, 8'd17, 0, 1'b0);
        run_cmd(3'd5, 8'd5, 8'd0, 0, 1'b0);
        run_cmd(3'd5, 8'd7, 8'd0, 0, 1'b0);
        run_cmd(3'd6, 8'd9, 8'd9, 0, 1'b0);
        run_cmd(3'd5, 8'd3, 8'd0, 0, 1'b0);
        run_cmd(3'd7, 8'd1, 8'd2, 0, 1'b0);
`ifdef ULA_SEQ_STATS_EN
        check("stat_ops_directed", 32'(stat_ops), 32'(hs_ops));
        check("stat_ovf_directed", 32'(stat_ovf), 32'(hs_ovf));
`endif

        // ---- backpressure with command pending ----
        run_cmd(3'd4, 8'd13, 8'd11, 10, 1'b1);
        @(negedge clk);
        check("no_second_accept", 32'(rsp_valid), 32'd0);

        // ---- randomized ----
        for (int n = 0; n < 200; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), 1'b0);
        end
`ifdef ULA_SEQ_STATS_EN
        check("stat_ops_random", 32'(stat_ops), 32'(hs_ops));
        check("stat_ovf_random", 32'(stat_ovf), 32'(hs_ovf));
`endif

        // ---- reset in the middle of a multiply ----
        run_cmd(3'd5, 8'd42, 8'd0, 0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd4;
        cmd_a = 8'd200;
        cmd_b = 8'd255;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_alu_f", 32'(alu_f), 32'd0);
        check("abort_alu_a", 32'(alu_a), 32'd0);
        acc_q = '0;
        hs_ops = 0;
        hs_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        run_cmd(3'd5, 8'd0, 8'd0, 0, 1'b0);
`ifdef ULA_SEQ_STATS_EN
        check("stat_ops_after_rst", 32'(stat_ops), 32'(hs_ops));
        check("stat_ovf_after_rst", 32'(stat_ovf), 32'(hs_ovf));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
